// File: rtl/seq_shift_multiplier_if.sv
// seq_shift_multiplier_if
// Operand/result handshake bundle for seq_shift_multiplier.
// The master side issues operands and consumes products; the slave side is
// the multiplier itself.
interface seq_shift_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 sgn;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out;

    modport master (
        output in_valid, a, b, sgn, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, a, b, sgn, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/seq_shift_multiplier.sv
// seq_shift_multiplier
// Multi-cycle shift-and-add multiplier retiring BITS_PER_CYCLE multiplier
// bits per clock, with per-operation signed/unsigned mode and valid/ready
// handshakes on both sides. Signed operands are reduced to magnitudes on
// acceptance and the sign is re-applied when the product is loaded.
// Optional feature macro: MULT_EARLY_EXIT_EN -- finish as soon as the
// remaining multiplier bits are all zero instead of always running
// WIDTH/BITS_PER_CYCLE steps.
module seq_shift_multiplier #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_shift_multiplier_if.slave io_bus
);
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_out;
    logic [PW-1:0]      r_mcand;     // |a|, pre-shifted to the current step's weight
    logic [WIDTH-1:0]   r_mag_b;     // |b|, remaining unconsumed bits
    logic [CNT_W-1:0]   r_step;
    logic               r_neg;

    logic               w_accept;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_neg;
    logic [PW-1:0]      w_pp;
    logic [PW-1:0]      w_acc_sum;
    logic [WIDTH-1:0]   w_mag_b_shift;
    logic               w_last_step;
    logic               w_finish;

    assign w_accept = (r_state == S_IDLE) && io_bus.in_valid;

    // Magnitudes fit in WIDTH bits unsigned, including |-2^(WIDTH-1)|.
    assign w_mag_a = (io_bus.sgn && io_bus.a[WIDTH-1]) ? -io_bus.a : io_bus.a;
    assign w_mag_b = (io_bus.sgn && io_bus.b[WIDTH-1]) ? -io_bus.b : io_bus.b;
    assign w_neg   = io_bus.sgn && (io_bus.a[WIDTH-1] ^ io_bus.b[WIDTH-1]);

    // Partial product of |a| and the low BITS_PER_CYCLE bits of |b|.
    // NOTE: w_pp gets its default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_mag_b[i]) begin
                w_pp = w_pp + (r_mcand << i);
            end
        end
    end

    assign w_acc_sum     = r_acc + w_pp;
    assign w_mag_b_shift = r_mag_b >> BITS_PER_CYCLE;
    assign w_last_step   = (r_step == CNT_W'(STEPS - 1));

`ifdef MULT_EARLY_EXIT_EN
    assign w_finish = w_last_step || (w_mag_b_shift == '0);
`else
    assign w_finish = w_last_step;
`endif

    // State register; reset has priority over every handshake.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (io_bus.in_valid)  w_state_next = S_CALC;
            S_CALC: if (w_finish)         w_state_next = S_DONE;
            S_DONE: if (io_bus.out_ready) w_state_next = S_IDLE;
            default:                      w_state_next = S_IDLE;
        endcase
    end

    // Accumulator and result register: cleared by reset, result loaded on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_out <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_sum;
            if (w_finish) begin
                r_out <= r_neg ? -w_acc_sum : w_acc_sum;
            end
        end
    end

    // Operand and step registers: always written on acceptance before they are used.
    // NOTE: these are deliberately left out of reset; every operation reloads them first.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mcand <= PW'(w_mag_a);
            r_mag_b <= w_mag_b;
            r_neg   <= w_neg;
            r_step  <= '0;
        end else if (r_state == S_CALC) begin
            r_mcand <= r_mcand << BITS_PER_CYCLE;
            r_mag_b <= w_mag_b_shift;
            r_step  <= r_step + CNT_W'(1);
        end
    end

    assign io_bus.in_ready  = (r_state == S_IDLE);
    assign io_bus.out_valid = (r_state == S_DONE);
    assign io_bus.out       = r_out;

endmodule

// File: tb/tb_seq_shift_multiplier.sv
// tb_seq_shift_multiplier
// Scoreboarded bench for seq_shift_multiplier: an 8-bit/1-bit-per-cycle
// instance carries most stimulus, a 16-bit/4-bit-per-cycle instance covers
// the wide configuration. Expected latency follows MULT_EARLY_EXIT_EN.
module tb_seq_shift_multiplier;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_shift_multiplier_if #(.WIDTH(8))  m8 ();
    seq_shift_multiplier_if #(.WIDTH(16)) m16 ();

    seq_shift_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (m8)
    );

    seq_shift_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (m16)
    );

    typedef struct {
        logic [31:0] prod;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference product, truncated to 2*w bits.
    function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b,
                                               input logic s, input int w);
        longint      sa, sb;
        logic [63:0] p, mask;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        p    = 64'(sa * sb);
        mask = (64'(1) << (2 * w)) - 64'(1);
        return 32'(p & mask);
    endfunction

    // Reference latency in CALC edges after the acceptance edge.
    function automatic int model_lat(input logic [15:0] b, input logic s, input int w, input int k);
        int          steps;
        int          n;
        logic [31:0] mag;
        steps = w / k;
        mag   = 32'(b);
        if (s && b[w-1]) mag = (32'(1) << w) - mag;
        n = steps;
`ifdef MULT_EARLY_EXIT_EN
        n = 1;
        while (n < steps && (mag >> (n * k)) != 0) n++;
`endif
        return n;
    endfunction

    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while (!m8.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!m8.in_ready) check("idle8_timeout", 32'(m8.in_ready), 32'd1);
    endtask

    // One 8-bit operation; hold > 0 keeps out_ready low for that many DONE cycles.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input int hold, input logic [31:0] want, input bit use_want);
        exp_t e;
        int   n;
        wait_idle8();
        m8.out_ready = (hold == 0);
        m8.a         = a;
        m8.b         = b;
        m8.sgn       = s;
        m8.in_valid  = 1'b1;
        e.prod = use_want ? want : model_prod(16'(a), 16'(b), s, 8);
        e.lat  = model_lat(16'(b), s, 8, 1);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        m8.in_valid = 1'b0;
        m8.a        = ~a;
        m8.b        = ~b;
        m8.sgn      = ~s;
        n = 0;
        while (!m8.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb_q.pop_front();
        check({tag, "_lat"}, 32'(n), 32'(e.lat));
        check({tag, "_out"}, 32'(m8.out), e.prod);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({tag, "_bp_valid"}, 32'(m8.out_valid), 32'd1);
                check({tag, "_bp_out"},   32'(m8.out), e.prod);
                check({tag, "_bp_ready"}, 32'(m8.in_ready), 32'd0);
            end
            @(negedge clk);
            m8.out_ready = 1'b1;
            @(posedge clk);
            #1;
            check({tag, "_drain_valid"}, 32'(m8.out_valid), 32'd0);
            check({tag, "_drain_ready"}, 32'(m8.in_ready), 32'd1);
        end
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [31:0] want, input bit use_want);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!m16.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        m16.a        = a;
        m16.b        = b;
        m16.sgn      = s;
        m16.in_valid = 1'b1;
        e.prod = use_want ? want : model_prod(a, b, s, 16);
        e.lat  = model_lat(b, s, 16, 4);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        m16.in_valid = 1'b0;
        n = 0;
        while (!m16.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb_q.pop_front();
        check({tag, "_lat"}, 32'(n), 32'(e.lat));
        check({tag, "_out"}, m16.out, e.prod);
    endtask

    initial begin
        rst           = 1'b1;
        m8.in_valid   = 1'b0;
        m8.a          = '0;
        m8.b          = '0;
        m8.sgn        = 1'b0;
        m8.out_ready  = 1'b1;
        m16.in_valid  = 1'b0;
        m16.a         = '0;
        m16.b         = '0;
        m16.sgn       = 1'b0;
        m16.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(m8.in_ready), 32'd1);
        check("rst_out_valid", 32'(m8.out_valid), 32'd0);
        check("rst_out",       32'(m8.out), 32'd0);
        check("rst16_out",     m16.out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run8("u_255x255", 8'd255, 8'd255, 1'b0, 0, 32'h0000_FE01, 1'b1);
        run8("s_m128sq",  8'h80,  8'h80,  1'b1, 0, 32'h0000_4000, 1'b1);
        run8("s_m3x5",    8'hFD,  8'h05,  1'b1, 0, 32'h0000_FFF1, 1'b1);
        run8("u_9x3",     8'd9,   8'd3,   1'b0, 0, 32'h0000_001B, 1'b1);
        run8("u_b0",      8'd77,  8'd0,   1'b0, 0, 32'h0000_0000, 1'b1);
        run8("bp_12x10",  8'd12,  8'd10,  1'b0, 5, 32'h0000_0078, 1'b1);

        // Reset in the middle of 200*3: asserted so it is sampled at E3.
        wait_idle8();
        m8.a        = 8'd200;
        m8.b        = 8'd3;
        m8.sgn      = 1'b0;
        m8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        m8.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(m8.out_valid), 32'd0);
        check("midrst_out",       32'(m8.out), 32'd0);
        check("midrst_in_ready",  32'(m8.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run8("after_rst_7x6", 8'd7, 8'd6, 1'b0, 0, 32'h0000_002A, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run8("rand8", 8'($urandom), 8'($urandom), 1'($urandom), 0, 32'd0, 1'b0);
        end

        run16("w_8000x7fff", 16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run16("rand16", 16'($urandom), 16'($urandom), 1'($urandom), 32'd0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
